// File: rtl/mant_mul_pipe_if.sv
// Handshake and data bundle for mant_mul_pipe: operand/tag input channel and result channel.
// The master drives operands and out_ready; the slave (the multiplier) returns the result.
interface mant_mul_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A_in;
  logic [WIDTH-1:0]     B_in;
  logic [TAG_W-1:0]     tag_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P_out;
  logic                 norm_hi;
  logic                 zero;
  logic [TAG_W-1:0]     tag_out;
  logic                 busy;

  modport master (
    output in_valid, A_in, B_in, tag_in, out_ready,
    input  in_ready, out_valid, P_out, norm_hi, zero, tag_out, busy
  );

  modport slave (
    input  in_valid, A_in, B_in, tag_in, out_ready,
    output in_ready, out_valid, P_out, norm_hi, zero, tag_out, busy
  );
endinterface

// File: rtl/mant_mul_pipe.sv
// Fully pipelined unsigned mantissa multiplier, fixed latency of STAGES cycles, with a
// global-stall valid/ready handshake, sideband tag and normalisation/zero flags.
module mant_mul_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic            clk,
  input  logic            RST,
  mant_mul_pipe_if.slave  bus
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned LoW = WIDTH / 2;
  localparam int unsigned HiW = WIDTH - LoW;

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [PW-1:0]     prod_d;
  logic [PW-1:0]     p_q;
  logic              norm_q, zero_q;

  // Whole pipe advances together; bubbles are kept, never collapsed.
  assign adv          = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv && !RST;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = bus.in_valid;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      if (vld_d[0]) tag_q[0] <= bus.tag_in;
      for (int i = 1; i < STAGES; i++) begin
        if (vld_d[i]) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Output stage only loads real results so P_out/tag_out keep their last value in bubbles.
  always_ff @(posedge clk) begin
    if (RST) begin
      p_q    <= '0;
      norm_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv && vld_d[STAGES-1]) begin
      p_q    <= prod_d;
      norm_q <= prod_d[PW-1];
      zero_q <= (prod_d == '0);
    end
  end

  if (STAGES == 1) begin : g_s1
    assign prod_d = {{WIDTH{1'b0}}, bus.A_in} * {{WIDTH{1'b0}}, bus.B_in};
  end else begin : g_ops
    logic [WIDTH-1:0] a_q, b_q;

    always_ff @(posedge clk) begin
      if (adv && vld_d[0]) begin
        a_q <= bus.A_in;
        b_q <= bus.B_in;
      end
    end

    if (STAGES == 2) begin : g_s2
      assign prod_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end else begin : g_split
      // Multiplier split into low/high halves of B; index j holds pipeline stage j+1.
      logic [WIDTH+LoW-1:0] lo_q [STAGES-2];
      logic [WIDTH+HiW-1:0] hi_q [STAGES-2];

      always_ff @(posedge clk) begin
        if (adv) begin
          if (vld_d[1]) begin
            lo_q[0] <= {{LoW{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[LoW-1:0]};
            hi_q[0] <= {{HiW{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[WIDTH-1:LoW]};
          end
          for (int j = 1; j < STAGES - 2; j++) begin
            if (vld_d[j+1]) begin
              lo_q[j] <= lo_q[j-1];
              hi_q[j] <= hi_q[j-1];
            end
          end
        end
      end

      assign prod_d = {{HiW{1'b0}}, lo_q[STAGES-3]} + ({{LoW{1'b0}}, hi_q[STAGES-3]} << LoW);
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.P_out     = p_q;
  assign bus.norm_hi   = norm_q;
  assign bus.zero      = zero_q;
  assign bus.tag_out   = tag_q[STAGES-1];
  assign bus.busy      = |vld_q;

endmodule

// File: tb/tb_mant_mul_pipe.sv
// Directed bench for mant_mul_pipe: default config plus (11,3), (24,4) and (2,1) variants,
// covering latency, tags, flags, backpressure hold and mid-operation reset.
module tb_mant_mul_pipe;
  logic clk;
  logic RST;
  int   n_checks;
  int   n_fail;

  mant_mul_pipe_if #(.WIDTH(8),  .TAG_W(4))  i8  ();
  mant_mul_pipe_if #(.WIDTH(11), .TAG_W(4))  i11 ();
  mant_mul_pipe_if #(.WIDTH(24), .TAG_W(16)) i24 ();
  mant_mul_pipe_if #(.WIDTH(2),  .TAG_W(1))  i2  ();

  mant_mul_pipe #(.WIDTH(8),  .STAGES(2), .TAG_W(4))  u8  (.clk(clk), .RST(RST), .bus(i8));
  mant_mul_pipe #(.WIDTH(11), .STAGES(3), .TAG_W(4))  u11 (.clk(clk), .RST(RST), .bus(i11));
  mant_mul_pipe #(.WIDTH(24), .STAGES(4), .TAG_W(16)) u24 (.clk(clk), .RST(RST), .bus(i24));
  mant_mul_pipe #(.WIDTH(2),  .STAGES(1), .TAG_W(1))  u2  (.clk(clk), .RST(RST), .bus(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1;
    i8.in_valid  = 1'b0; i8.A_in  = '0; i8.B_in  = '0; i8.tag_in  = '0; i8.out_ready  = 1'b1;
    i11.in_valid = 1'b0; i11.A_in = '0; i11.B_in = '0; i11.tag_in = '0; i11.out_ready = 1'b1;
    i24.in_valid = 1'b0; i24.A_in = '0; i24.B_in = '0; i24.tag_in = '0; i24.out_ready = 1'b1;
    i2.in_valid  = 1'b0; i2.A_in  = '0; i2.B_in  = '0; i2.tag_in  = '0; i2.out_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 64'(i8.out_valid), 64'h0);
    chk("rst_busy",      64'(i8.busy),      64'h0);
    chk("rst_zero",      64'(i8.zero),      64'h0);
    chk("rst_p_out",     64'(i8.P_out),     64'h0);
    chk("rst_tag_out",   64'(i8.tag_out),   64'h0);
    chk("rst_norm_hi",   64'(i8.norm_hi),   64'h0);
    chk("rst_in_ready",  64'(i8.in_ready),  64'h0);
    chk("rst_ov_w24",    64'(i24.out_valid), 64'h0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(i8.in_ready), 64'h1);

    // Back-to-back ops on default config
    i8.in_valid = 1'b1; i8.A_in = 8'hFF; i8.B_in = 8'hFF; i8.tag_in = 4'd1;
    tick();
    chk("b2b_ov_lat1", 64'(i8.out_valid), 64'h0);
    chk("b2b_busy",    64'(i8.busy),      64'h1);
    i8.A_in = 8'h80; i8.B_in = 8'h80; i8.tag_in = 4'd2;
    tick();
    chk("b2b1_ov",   64'(i8.out_valid), 64'h1);
    chk("b2b1_p",    64'(i8.P_out),     64'hFE01);
    chk("b2b1_norm", 64'(i8.norm_hi),   64'h1);
    chk("b2b1_zero", 64'(i8.zero),      64'h0);
    chk("b2b1_tag",  64'(i8.tag_out),   64'h1);
    i8.A_in = 8'h00; i8.B_in = 8'h5A; i8.tag_in = 4'd3;
    tick();
    chk("b2b2_ov",   64'(i8.out_valid), 64'h1);
    chk("b2b2_p",    64'(i8.P_out),     64'h4000);
    chk("b2b2_norm", 64'(i8.norm_hi),   64'h0);
    chk("b2b2_tag",  64'(i8.tag_out),   64'h2);
    i8.in_valid = 1'b0; i8.A_in = 8'hFF; i8.B_in = 8'hFF; i8.tag_in = 4'hF;
    tick();
    chk("b2b3_ov",   64'(i8.out_valid), 64'h1);
    chk("b2b3_p",    64'(i8.P_out),     64'h0);
    chk("b2b3_zero", 64'(i8.zero),      64'h1);
    chk("b2b3_tag",  64'(i8.tag_out),   64'h3);
    tick();
    chk("b2b_drain_ov",   64'(i8.out_valid), 64'h0);
    chk("b2b_drain_busy", 64'(i8.busy),      64'h0);

    // Backpressure with out_ready low
    i8.out_ready = 1'b0;
    i8.in_valid = 1'b1; i8.A_in = 8'h81; i8.B_in = 8'h83; i8.tag_in = 4'd5;
    tick();
    chk("bp_ov0",   64'(i8.out_valid), 64'h0);
    chk("bp_busy",  64'(i8.busy),      64'h1);
    i8.A_in = 8'h02; i8.B_in = 8'h03; i8.tag_in = 4'd6;
    tick();
    chk("bp_ov1",   64'(i8.out_valid), 64'h1);
    chk("bp_p",     64'(i8.P_out),     64'h4203);
    chk("bp_zero",  64'(i8.zero),      64'h0);
    chk("bp_inrdy", 64'(i8.in_ready),  64'h0);
    i8.A_in = 8'h10; i8.B_in = 8'h10; i8.tag_in = 4'd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_p",     64'(i8.P_out),     64'h4203);
      chk("bp_hold_tag",   64'(i8.tag_out),   64'h5);
      chk("bp_hold_ov",    64'(i8.out_valid), 64'h1);
      chk("bp_hold_inrdy", 64'(i8.in_ready),  64'h0);
    end
    i8.in_valid = 1'b0;
    #1;
    chk("bp_inrdy_indep", 64'(i8.in_ready), 64'h0);
    i8.in_valid = 1'b1;
    i8.out_ready = 1'b1;
    #1;
    chk("bp_release_inrdy", 64'(i8.in_ready), 64'h1);
    tick();
    chk("bp_next_ov",  64'(i8.out_valid), 64'h1);
    chk("bp_next_p",   64'(i8.P_out),     64'h0006);
    chk("bp_next_tag", 64'(i8.tag_out),   64'h6);
    i8.in_valid = 1'b0;
    tick();
    chk("bp_last_ov",  64'(i8.out_valid), 64'h1);
    chk("bp_last_p",   64'(i8.P_out),     64'h0100);
    chk("bp_last_tag", 64'(i8.tag_out),   64'h7);
    tick();
    chk("bp_drain_ov",   64'(i8.out_valid), 64'h0);
    chk("bp_drain_busy", 64'(i8.busy),      64'h0);

    // Reset mid-operation
    i8.in_valid = 1'b1; i8.A_in = 8'h00; i8.B_in = 8'h12; i8.tag_in = 4'd9;
    tick();
    i8.A_in = 8'h03; i8.B_in = 8'h03; i8.tag_in = 4'hA;
    tick();
    chk("mr_pre_ov",   64'(i8.out_valid), 64'h1);
    chk("mr_pre_zero", 64'(i8.zero),      64'h1);
    i8.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("mr_inrdy_rst", 64'(i8.in_ready), 64'h0);
    tick();
    chk("mr_ov",   64'(i8.out_valid), 64'h0);
    chk("mr_busy", 64'(i8.busy),      64'h0);
    chk("mr_zero", 64'(i8.zero),      64'h0);
    RST = 1'b0;
    #1;
    chk("mr_inrdy_after", 64'(i8.in_ready), 64'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_emit", 64'(i8.out_valid), 64'h0);
    end

    // WIDTH=11, STAGES=3
    i11.in_valid = 1'b1; i11.A_in = 11'h7FF; i11.B_in = 11'h7FF; i11.tag_in = 4'd3;
    tick();
    chk("w11_lat1", 64'(i11.out_valid), 64'h0);
    i11.A_in = 11'h5A3; i11.B_in = 11'h1C7; i11.tag_in = 4'd4;
    tick();
    chk("w11_lat2", 64'(i11.out_valid), 64'h0);
    i11.in_valid = 1'b0;
    tick();
    chk("w11_a_ov",   64'(i11.out_valid), 64'h1);
    chk("w11_a_p",    64'(i11.P_out),     64'h3FF001);
    chk("w11_a_norm", 64'(i11.norm_hi),   64'h1);
    chk("w11_a_tag",  64'(i11.tag_out),   64'h3);
    tick();
    chk("w11_b_p",    64'(i11.P_out),     64'h0A04B5);
    chk("w11_b_norm", 64'(i11.norm_hi),   64'h0);
    chk("w11_b_tag",  64'(i11.tag_out),   64'h4);
    tick();
    chk("w11_drain", 64'(i11.out_valid), 64'h0);

    // WIDTH=24, STAGES=4
    i24.in_valid = 1'b1; i24.A_in = 24'h800000; i24.B_in = 24'h800000; i24.tag_in = 16'hBEEF;
    tick();
    chk("w24_lat1", 64'(i24.out_valid), 64'h0);
    i24.A_in = 24'hFFFFFF; i24.B_in = 24'hFFFFFF; i24.tag_in = 16'h1234;
    tick();
    chk("w24_lat2", 64'(i24.out_valid), 64'h0);
    i24.in_valid = 1'b0;
    tick();
    chk("w24_lat3", 64'(i24.out_valid), 64'h0);
    tick();
    chk("w24_a_ov",   64'(i24.out_valid), 64'h1);
    chk("w24_a_p",    64'(i24.P_out),     64'h4000_0000_0000);
    chk("w24_a_norm", 64'(i24.norm_hi),   64'h0);
    chk("w24_a_tag",  64'(i24.tag_out),   64'hBEEF);
    tick();
    chk("w24_b_p",    64'(i24.P_out),     64'hFFFF_FE00_0001);
    chk("w24_b_norm", 64'(i24.norm_hi),   64'h1);
    chk("w24_b_tag",  64'(i24.tag_out),   64'h1234);
    tick();
    chk("w24_drain", 64'(i24.out_valid), 64'h0);

    // WIDTH=2, STAGES=1
    i2.in_valid = 1'b1; i2.A_in = 2'd3; i2.B_in = 2'd3; i2.tag_in = 1'b1;
    tick();
    chk("w2_a_ov",   64'(i2.out_valid), 64'h1);
    chk("w2_a_p",    64'(i2.P_out),     64'h9);
    chk("w2_a_norm", 64'(i2.norm_hi),   64'h1);
    chk("w2_a_tag",  64'(i2.tag_out),   64'h1);
    i2.A_in = 2'd2; i2.B_in = 2'd1; i2.tag_in = 1'b0;
    tick();
    chk("w2_b_p",    64'(i2.P_out),     64'h2);
    chk("w2_b_norm", 64'(i2.norm_hi),   64'h0);
    chk("w2_b_tag",  64'(i2.tag_out),   64'h0);
    i2.in_valid = 1'b0;
    tick();
    chk("w2_drain", 64'(i2.out_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
